// File: rtl/spi_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_seq_ctrl_pkg
// Shared definitions for the SPI transfer sequencer:
//   - MC0 SPI mode opcodes (SPI_SEND / SPI_RECEIVE) and their width
//   - sequencer FSM state encoding
//   - helper that folds every non-RECEIVE mode onto SEND
// ---------------------------------------------------------------------------
package spi_seq_ctrl_pkg;

   localparam int W_SPI_MODE   = 2;
   localparam int W_SPIC_STATE = 3;

   localparam logic [W_SPI_MODE-1:0] SPI_SEND    = 2'd0;
   localparam logic [W_SPI_MODE-1:0] SPI_RECEIVE = 2'd1;

   typedef enum logic [W_SPIC_STATE-1:0] {
      SPIC_IDLE  = 3'd0,
      SPIC_SETUP = 3'd1,
      SPIC_SHIFT = 3'd2,
      SPIC_HOLD  = 3'd3,
      SPIC_DONE  = 3'd4
   } spic_state_t;

   // Only the exact RECEIVE code receives; anything else transmits.
   function automatic logic is_receive(input logic [W_SPI_MODE-1:0] mode);
      return (mode == SPI_RECEIVE);
   endfunction

endpackage

// File: rtl/spi_seq_ctrl_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// SCLK generator. While enabled, counts CLK_DIV system clocks per SCLK
// half-period and toggles a registered SCLK (starting low). The tick
// outputs are asserted in the cycle *before* SCLK changes, so logic using
// them acts on the same clk edge where SCLK rises or falls.
// Ports:
//   i_clk, i_rst   system clock, async active-high reset
//   i_en           run the divider; low clears counter and SCLK
//   o_rise_tick    SCLK goes 0->1 at the next clk edge
//   o_fall_tick    SCLK goes 1->0 at the next clk edge
//   o_sclk         registered SCLK
// ---------------------------------------------------------------------------
module spi_clk_div
   import spi_seq_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_rise_tick,
   output logic o_fall_tick,
   output logic o_sclk
);

   localparam int               W_CNT    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(CLK_DIV - 1);

   logic [W_CNT-1:0] r_cnt;
   logic             r_sclk;
   logic             w_tick;

   assign w_tick      = i_en & (r_cnt == CNT_LAST);
   assign o_rise_tick = w_tick & ~r_sclk;
   assign o_fall_tick = w_tick &  r_sclk;
   assign o_sclk      = r_sclk;

   // Half-period counter and SCLK toggle flop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (w_tick) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_sclk <= r_sclk;
      end
   end

endmodule

// File: rtl/spi_seq_ctrl.sv
// ---------------------------------------------------------------------------
// spi_seq_ctrl
// Performs one full-word SPI mode-0 transfer per MC0 request and stalls the
// CPU for its duration. IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
// Ports:
//   i_clk, i_rst        system clock, async active-high reset
//   i_start             request, sampled in IDLE only
//   i_spi_mode          SPI_SEND / SPI_RECEIVE, captured with i_start
//   i_tx_data           word to send, captured with i_start
//   i_miso              serial data from slave
//   o_sclk/o_mosi/o_cs_n  SPI pins (CPOL=0, MSB first, active-low CS)
//   o_busy              registered, high in SETUP/SHIFT/HOLD
//   o_stall             CPU hold: busy, or a request pending in IDLE
//   o_rx_data           last received word
//   o_rx_valid          one-cycle pulse (DONE) when o_rx_data updates
// ---------------------------------------------------------------------------
module spi_seq_ctrl
   import spi_seq_ctrl_pkg::*;
#(
   parameter int W_DATA  = 32,
   parameter int CLK_DIV = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [W_SPI_MODE-1:0] i_spi_mode,
   input  logic [W_DATA-1:0]     i_tx_data,
   input  logic                  i_miso,
   output logic                  o_sclk,
   output logic                  o_mosi,
   output logic                  o_cs_n,
   output logic                  o_busy,
   output logic                  o_stall,
   output logic [W_DATA-1:0]     o_rx_data,
   output logic                  o_rx_valid
);

   localparam int               W_BIT    = $clog2(W_DATA) + 1;
   localparam int               W_PH     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W_PH-1:0]  PH_LAST  = W_PH'(CLK_DIV - 1);
   localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(W_DATA);

   spic_state_t       r_state;
   spic_state_t       w_state_nxt;
   logic [W_PH-1:0]   r_ph_cnt;
   logic [W_BIT-1:0]  r_bit_cnt;
   logic [W_DATA-1:0] r_tx_sh;
   logic [W_DATA-1:0] r_rx_sh;
   logic [W_DATA-1:0] r_rx_data;
   logic              r_recv;
   logic              r_mosi;
   logic              r_cs_n;
   logic              r_busy;
   logic              r_rx_valid;

   logic w_rise;
   logic w_fall;
   logic w_sclk;
   logic w_accept;
   logic w_last_fall;
   logic w_active_nxt;
   logic w_enter_done;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (r_state == SPIC_SHIFT),
      .o_rise_tick(w_rise),
      .o_fall_tick(w_fall),
      .o_sclk     (w_sclk)
   );

   assign w_accept     = (r_state == SPIC_IDLE) & i_start;
   // The falling edge after the last rising edge ends SHIFT with SCLK low.
   assign w_last_fall  = w_fall & (r_bit_cnt == BIT_LAST);
   assign w_active_nxt = (w_state_nxt == SPIC_SETUP) | (w_state_nxt == SPIC_SHIFT) |
                         (w_state_nxt == SPIC_HOLD);
   assign w_enter_done = (r_state == SPIC_HOLD) & (w_state_nxt == SPIC_DONE);

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SPIC_IDLE:  if (i_start)             w_state_nxt = SPIC_SETUP; else w_state_nxt = SPIC_IDLE;
         SPIC_SETUP: if (r_ph_cnt == PH_LAST) w_state_nxt = SPIC_SHIFT; else w_state_nxt = SPIC_SETUP;
         SPIC_SHIFT: if (w_last_fall)         w_state_nxt = SPIC_HOLD;  else w_state_nxt = SPIC_SHIFT;
         SPIC_HOLD:  if (r_ph_cnt == PH_LAST) w_state_nxt = SPIC_DONE;  else w_state_nxt = SPIC_HOLD;
         SPIC_DONE:  w_state_nxt = SPIC_IDLE;
         default:    w_state_nxt = SPIC_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= SPIC_IDLE;
      else       r_state <= w_state_nxt;
   end

   // SETUP/HOLD duration counter, restarted on every state change.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                                 r_ph_cnt <= '0;
      else if (w_state_nxt != r_state)                           r_ph_cnt <= '0;
      else if ((r_state == SPIC_SETUP) || (r_state == SPIC_HOLD)) r_ph_cnt <= r_ph_cnt + 1'b1;
      else                                                       r_ph_cnt <= '0;
   end

   // Rising-edge counter; cleared while idle so each word starts at zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                      r_bit_cnt <= '0;
      else if (r_state == SPIC_IDLE)  r_bit_cnt <= '0;
      else if (w_rise)                r_bit_cnt <= r_bit_cnt + 1'b1;
      else                            r_bit_cnt <= r_bit_cnt;
   end

   // Transmit path: load on request, advance on every falling edge except
   // the final one so MOSI keeps the last bit through HOLD.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_sh <= '0;
         r_recv  <= 1'b0;
         r_mosi  <= 1'b0;
      end else if (w_accept) begin
         r_tx_sh <= i_tx_data;
         r_recv  <= is_receive(i_spi_mode);
         r_mosi  <= is_receive(i_spi_mode) ? 1'b0 : i_tx_data[W_DATA-1];
      end else if (w_fall && !w_last_fall) begin
         r_tx_sh <= {r_tx_sh[W_DATA-2:0], 1'b0};
         r_recv  <= r_recv;
         r_mosi  <= r_recv ? 1'b0 : r_tx_sh[W_DATA-2];
      end else begin
         r_tx_sh <= r_tx_sh;
         r_recv  <= r_recv;
         r_mosi  <= r_mosi;
      end
   end

   // Receive shift register: MISO enters at the LSB on each SCLK rise.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_rx_sh <= '0;
      else if (w_accept) r_rx_sh <= '0;
      else if (w_rise)   r_rx_sh <= {r_rx_sh[W_DATA-2:0], i_miso};
      else               r_rx_sh <= r_rx_sh;
   end

   // Registered pin/status outputs, aligned with the state they describe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cs_n     <= 1'b1;
         r_busy     <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
      end else begin
         r_cs_n     <= ~w_active_nxt;
         r_busy     <= w_active_nxt;
         r_rx_valid <= w_enter_done & r_recv;
         r_rx_data  <= (w_enter_done & r_recv) ? r_rx_sh : r_rx_data;
      end
   end

   assign o_sclk     = w_sclk;
   assign o_mosi     = r_mosi;
   assign o_cs_n     = r_cs_n;
   assign o_busy     = r_busy;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   // Stall covers the request cycle itself; gated by reset so it reads 0
   // while reset is asserted.
   assign o_stall    = r_busy | (i_start & (r_state == SPIC_IDLE) & ~i_rst);

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_seq_ctrl
// Three sequencers (CLK_DIV = 4, 2, 1) share clock and reset. A per-cycle
// monitor acts as the SPI slave (captures MOSI on SCLK rise, presents the
// next MISO bit after each SCLK fall) and measures timing; each test task
// compares the measurements against figures derived from the transfer rules.
// ---------------------------------------------------------------------------
module tb_spi_seq_ctrl;
   import spi_seq_ctrl_pkg::*;

   localparam int W     = 32;
   localparam int N_DUT = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start_a    [N_DUT];
   logic [W_SPI_MODE-1:0] mode_a     [N_DUT];
   logic [W-1:0]          tx_a       [N_DUT];
   logic                  miso_a     [N_DUT];
   logic                  sclk_a     [N_DUT];
   logic                  mosi_a     [N_DUT];
   logic                  cs_n_a     [N_DUT];
   logic                  busy_a     [N_DUT];
   logic                  stall_a    [N_DUT];
   logic [W-1:0]          rx_data_a  [N_DUT];
   logic                  rx_valid_a [N_DUT];

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_rx [N_DUT];

   // Measurements from the most recent transfer.
   logic [W-1:0] m_cap;
   logic [W-1:0] m_rx_at_valid;
   int m_rise, m_cs_low, m_stall, m_valid_cnt, m_valid_cyc, m_done_cyc;
   int m_lead_high, m_per_err, m_mosi_err, m_stall_done;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      spi_seq_ctrl #(.W_DATA(W), .CLK_DIV((g == 0) ? 4 : ((g == 1) ? 2 : 1))) u_dut (
         .i_clk(clk), .i_rst(rst), .i_start(start_a[g]), .i_spi_mode(mode_a[g]),
         .i_tx_data(tx_a[g]), .i_miso(miso_a[g]), .o_sclk(sclk_a[g]), .o_mosi(mosi_a[g]),
         .o_cs_n(cs_n_a[g]), .o_busy(busy_a[g]), .o_stall(stall_a[g]),
         .o_rx_data(rx_data_a[g]), .o_rx_valid(rx_valid_a[g]));
   end

   function automatic int div_of(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
   endfunction

   // Entered and left at posedge+1. Cycle 0 is the request cycle.
   task automatic xfer(input int d, input logic [W_SPI_MODE-1:0] mode, input logic [W-1:0] tx,
                       input logic [W-1:0] sw, input bit keep, input int spike);
      int dv, c, bi, last_rise;
      bit prev_sclk, prev_mosi, seen_low, fin, recv, fell;
      dv = div_of(d);
      recv = (mode == SPI_RECEIVE);
      m_cap = '0; m_rx_at_valid = '0; m_rise = 0; m_cs_low = 0; m_stall = 0; m_valid_cnt = 0;
      m_valid_cyc = -1; m_done_cyc = -1; m_lead_high = 0; m_per_err = 0; m_mosi_err = 0;
      m_stall_done = -1;
      start_a[d] = 1'b1; mode_a[d] = mode; tx_a[d] = tx; miso_a[d] = sw[W-1];
      bi = W - 1; c = 0; last_rise = 0; prev_sclk = 1'b0; prev_mosi = mosi_a[d];
      seen_low = 1'b0; fin = 1'b0;
      while (!fin && c < 2*dv + 2*W*dv + 40) begin
         @(negedge clk);
         if (stall_a[d]) m_stall++;
         if (!cs_n_a[d]) begin
            m_cs_low++; seen_low = 1'b1;
         end else if (!seen_low) begin
            m_lead_high++;
         end else begin
            fin = 1'b1; m_done_cyc = c; m_stall_done = int'(stall_a[d]);
         end
         fell = !sclk_a[d] && prev_sclk;
         if (sclk_a[d] && !prev_sclk) begin
            m_rise++;
            m_cap = {m_cap[W-2:0], mosi_a[d]};
            if ((m_rise == 1) ? (c != 2*dv + 1) : (c - last_rise != 2*dv)) m_per_err++;
            last_rise = c;
         end
         if (fell) begin
            if (c - last_rise != dv) m_per_err++;
            if (bi > 0) begin bi--; miso_a[d] = sw[bi]; end
         end
         if ((mosi_a[d] !== prev_mosi) && (c != 1) && !fell) m_mosi_err++;
         if (recv && !cs_n_a[d] && (mosi_a[d] !== 1'b0)) m_mosi_err++;
         if (rx_valid_a[d]) begin
            m_valid_cnt++; m_valid_cyc = c; m_rx_at_valid = rx_data_a[d];
         end
         prev_sclk = sclk_a[d]; prev_mosi = mosi_a[d];
         @(posedge clk); #1;
         c++;
         start_a[d] = keep || (c == spike);
      end
      n_vec++; if (!fin) begin n_err++; $display("FAIL xfer_timeout dut%0d: no DONE within %0d cycles", d, c); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < N_DUT; d++) begin
         n_vec++; if ({sclk_a[d], mosi_a[d], cs_n_a[d], busy_a[d], stall_a[d], rx_valid_a[d]} !== 6'b001000) begin
            n_err++; $display("FAIL reset_pins dut%0d: got %b expected 001000", d,
                              {sclk_a[d], mosi_a[d], cs_n_a[d], busy_a[d], stall_a[d], rx_valid_a[d]});
         end
         n_vec++; if (rx_data_a[d] !== 32'h0) begin n_err++; $display("FAIL reset_rx dut%0d: got %h expected 0", d, rx_data_a[d]); end
         exp_rx[d] = 32'h0;
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_send();
      xfer(1, SPI_SEND, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 1'b0, -1);
      n_vec++; if (m_cap !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL send_word: got %h expected a5a50f0f", m_cap); end
      n_vec++; if (m_cs_low !== 2*2 + 2*W*2) begin n_err++; $display("FAIL send_cs_low: got %0d expected %0d", m_cs_low, 2*2 + 2*W*2); end
      n_vec++; if (m_rise !== W) begin n_err++; $display("FAIL send_rises: got %0d expected %0d", m_rise, W); end
      n_vec++; if (m_valid_cnt !== 0) begin n_err++; $display("FAIL send_no_valid: got %0d expected 0", m_valid_cnt); end
      n_vec++; if (rx_data_a[1] !== exp_rx[1]) begin n_err++; $display("FAIL send_rx_hold: got %h expected %h", rx_data_a[1], exp_rx[1]); end
      n_vec++; if (m_per_err + m_mosi_err !== 0) begin n_err++; $display("FAIL send_timing: got %0d/%0d errors expected 0", m_per_err, m_mosi_err); end
   endtask

   task automatic test_receive();
      xfer(0, SPI_RECEIVE, $urandom, 32'hDEAD_BEEF, 1'b0, -1);
      exp_rx[0] = 32'hDEAD_BEEF;
      n_vec++; if (m_rx_at_valid !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL recv_word: got %h expected deadbeef", m_rx_at_valid); end
      n_vec++; if (m_valid_cnt !== 1 || m_valid_cyc !== 265) begin
         n_err++; $display("FAIL recv_valid: got %0d pulses at cycle %0d expected 1 at 265", m_valid_cnt, m_valid_cyc); end
      n_vec++; if (m_mosi_err !== 0 || m_cap !== 32'h0) begin
         n_err++; $display("FAIL recv_mosi_zero: got %0d errors word %h expected 0", m_mosi_err, m_cap); end
      n_vec++; if (rx_data_a[0] !== exp_rx[0]) begin n_err++; $display("FAIL recv_rx_after: got %h expected %h", rx_data_a[0], exp_rx[0]); end
   endtask

   task automatic test_stall_rerequest();
      logic [W-1:0] tx;
      int bad;
      tx = $urandom;
      xfer(0, SPI_SEND, tx, $urandom, 1'b0, 100);
      n_vec++; if (m_stall !== 2*4 + 2*W*4 + 1) begin n_err++; $display("FAIL stall_len: got %0d expected 265", m_stall); end
      n_vec++; if (m_stall_done !== 0 || m_done_cyc !== 265) begin
         n_err++; $display("FAIL stall_done: got stall %0d at cycle %0d expected 0 at 265", m_stall_done, m_done_cyc); end
      n_vec++; if (m_cap !== tx) begin n_err++; $display("FAIL stall_word: got %h expected %h", m_cap, tx); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!cs_n_a[0] || busy_a[0]) bad++;
         @(posedge clk); #1;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL no_queued_start: got %0d busy cycles expected 0", bad); end
   endtask

   task automatic test_reset_mid();
      int rises, cyc;
      bit prev;
      start_a[0] = 1'b1; mode_a[0] = SPI_RECEIVE; tx_a[0] = $urandom;
      rises = 0; cyc = 0; prev = 1'b0;
      while (rises < 10 && cyc < 500) begin
         @(negedge clk);
         if (sclk_a[0] && !prev) rises++;
         prev = sclk_a[0];
         miso_a[0] = 1'($urandom);
         if (rises < 10) begin @(posedge clk); #1; start_a[0] = 1'b0; cyc++; end
      end
      n_vec++; if (rises !== 10) begin n_err++; $display("FAIL rst_mid_reach: got %0d rises expected 10", rises); end
      #1 rst = 1'b1;
      #1;
      n_vec++; if ({cs_n_a[0], sclk_a[0], stall_a[0], busy_a[0], rx_valid_a[0]} !== 5'b10000) begin
         n_err++; $display("FAIL rst_mid_pins: got %b expected 10000",
                           {cs_n_a[0], sclk_a[0], stall_a[0], busy_a[0], rx_valid_a[0]}); end
      n_vec++; if (rx_data_a[0] !== 32'h0) begin n_err++; $display("FAIL rst_mid_rx: got %h expected 0", rx_data_a[0]); end
      @(posedge clk); #1;
      rst = 1'b0; start_a[0] = 1'b0;
      for (int d = 0; d < N_DUT; d++) exp_rx[d] = 32'h0;
      @(posedge clk); #1;
      xfer(0, SPI_RECEIVE, $urandom, 32'h1234_5678, 1'b0, -1);
      exp_rx[0] = 32'h1234_5678;
      n_vec++; if (rx_data_a[0] !== exp_rx[0] || m_valid_cnt !== 1) begin
         n_err++; $display("FAIL rst_mid_fresh: got %h (%0d pulses) expected 12345678 (1)", rx_data_a[0], m_valid_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] cap1;
      int done1;
      xfer(0, SPI_SEND, 32'hFFFF_FFFF, $urandom, 1'b1, -1);
      cap1 = m_cap; done1 = m_done_cyc;
      xfer(0, SPI_SEND, 32'h0000_0001, $urandom, 1'b0, -1);
      n_vec++; if (cap1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_word1: got %h expected ffffffff", cap1); end
      n_vec++; if (m_cap !== 32'h0000_0001) begin n_err++; $display("FAIL b2b_word2: got %h expected 00000001", m_cap); end
      n_vec++; if (m_lead_high + 1 !== 2) begin n_err++; $display("FAIL b2b_cs_gap: got %0d expected 2", m_lead_high + 1); end
      n_vec++; if (done1 !== 265 || m_done_cyc !== 265) begin
         n_err++; $display("FAIL b2b_len: got %0d/%0d expected 265/265", done1, m_done_cyc); end
   endtask

   task automatic test_div1();
      xfer(2, SPI_SEND, 32'h8000_0001, $urandom, 1'b0, -1);
      n_vec++; if (m_rise !== W || m_per_err !== 0) begin
         n_err++; $display("FAIL div1_sclk: got %0d rises, %0d period errors expected %0d, 0", m_rise, m_per_err, W); end
      n_vec++; if (m_cap[W-1] !== 1'b1 || m_cap[0] !== 1'b1) begin
         n_err++; $display("FAIL div1_end_bits: got %b/%b expected 1/1", m_cap[W-1], m_cap[0]); end
      n_vec++; if (m_cap !== 32'h8000_0001) begin n_err++; $display("FAIL div1_word: got %h expected 80000001", m_cap); end
      n_vec++; if (m_done_cyc !== 2 + 2*W + 1) begin n_err++; $display("FAIL div1_len: got %0d expected %0d", m_done_cyc, 2 + 2*W + 1); end
   endtask

   task automatic test_random();
      int d, dv, len;
      logic [W_SPI_MODE-1:0] mode;
      logic [W-1:0] tx, sw, exp_cap;
      bit recv;
      for (int i = 0; i < 8; i++) begin
         d = $urandom_range(0, N_DUT - 1);
         dv = div_of(d);
         mode = (i == 0) ? 2'd3 : W_SPI_MODE'($urandom_range(0, 3));
         tx = $urandom; sw = $urandom;
         recv = (mode == SPI_RECEIVE);
         exp_cap = recv ? 32'h0 : tx;
         if (recv) exp_rx[d] = sw;
         len = 2*dv + 2*W*dv + 1;
         xfer(d, mode, tx, sw, 1'b0, -1);
         n_vec++; if (m_cap !== exp_cap) begin n_err++; $display("FAIL rnd%0d_mosi: got %h expected %h", i, m_cap, exp_cap); end
         n_vec++; if (rx_data_a[d] !== exp_rx[d]) begin n_err++; $display("FAIL rnd%0d_rx: got %h expected %h", i, rx_data_a[d], exp_rx[d]); end
         n_vec++; if (m_valid_cnt !== int'(recv)) begin n_err++; $display("FAIL rnd%0d_valid: got %0d expected %0d", i, m_valid_cnt, int'(recv)); end
         n_vec++; if (m_done_cyc !== len || m_stall !== len) begin
            n_err++; $display("FAIL rnd%0d_len: got done %0d stall %0d expected %0d", i, m_done_cyc, m_stall, len); end
         n_vec++; if (m_per_err + m_mosi_err !== 0) begin
            n_err++; $display("FAIL rnd%0d_timing: got %0d/%0d errors expected 0", i, m_per_err, m_mosi_err); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < N_DUT; d++) begin
         start_a[d] = 1'b0; mode_a[d] = SPI_SEND; tx_a[d] = 32'h0; miso_a[d] = 1'b0; exp_rx[d] = 32'h0;
      end
      test_reset();
      test_send();
      test_receive();
      test_stall_rerequest();
      test_reset_mid();
      test_back_to_back();
      test_div1();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
